cga_scandbl_ctrl: RTL and testbench

//  Timing sequencer for the CGA line-doubler datapath. Watches the
//  CGA-rate hsync/vsync (pixel rate clk/2, 1824 clk per input line), qualifies

---
 rtl/cga_scandbl_ctrl_if.sv | 24 ++
 rtl/cga_scandbl_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cga_scandbl_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cga_scandbl_ctrl_if.sv
// Signal bundle between the CGA-side timing source (master) and the
// line-doubler sequencer (slave).
interface cga_scandbl_ctrl_if;
  // No handshake: enable/hsync/vsync are level inputs in the clk domain,
  // line_reset is a 1-clk strobe, everything else is a registered level.
  logic       enable;
  logic       hsync;
  logic       vsync;
  logic       line_reset;
  logic       dbl_vsync;
  logic       locked;
  logic [9:0] dbl_line;
  logic [1:0] state_dbg;

  modport master (
    output enable, hsync, vsync,
    input  line_reset, dbl_vsync, locked, dbl_line, state_dbg
  );

  modport slave (
    input  enable, hsync, vsync,
    output line_reset, dbl_vsync, locked, dbl_line, state_dbg
  );
endinterface

// File: rtl/cga_scandbl_ctrl.sv
// CGA line-doubler timing sequencer: qualifies hsync lock, issues per-line
// buffer-swap pulses and produces doubled-rate vsync and line count.
module cga_scandbl_ctrl #(
  parameter int HTOTAL       = 1824,
  parameter int HTOL         = 32,
  parameter int LOCK_LINES   = 4,
  parameter int TIMEOUT      = 4095,
  parameter int VS_DBL_LINES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  cga_scandbl_ctrl_if.slave  bus
);

  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam int CW = $clog2(VS_DBL_LINES + 1);

  localparam logic [11:0]   WIN_LO   = 12'(HTOTAL - HTOL);
  localparam logic [11:0]   WIN_HI   = 12'(HTOTAL + HTOL);
  localparam logic [11:0]   MID_CNT  = 12'(HTOTAL / 2 - 1);
  localparam logic [11:0]   TMO_CNT  = 12'(TIMEOUT);
  localparam logic [GW-1:0] LOCK_CNT = GW'(LOCK_LINES);
  localparam logic [CW-1:0] VS_CNT   = CW'(VS_DBL_LINES);
  localparam logic [CW-1:0] VS_ONE   = CW'(1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d, hs_rise_q, hs_rise_d;
  logic        vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_rise_q, vs_rise_d;
  logic [11:0] pcnt_q, pcnt_d;
  logic [GW-1:0] good_q, good_d;
  logic [CW-1:0] vs_cnt_q, vs_cnt_d;
  logic [9:0]  dbl_line_q, dbl_line_d;
  logic        line_reset_q, line_reset_d;
  logic        dbl_vsync_q, dbl_vsync_d;
  logic        locked_q, locked_d;

  logic        in_win;
  logic        timeout;
  logic        stay_locked;
  logic        tick;

  always_comb begin
    hs_s1_d   = bus.hsync;
    hs_s2_d   = hs_s1_q;
    hs_rise_d = hs_s1_q & ~hs_s2_q;
    vs_s1_d   = bus.vsync;
    vs_s2_d   = vs_s1_q;
    vs_rise_d = vs_s1_q & ~vs_s2_q;

    // Rises are registered so the swap pulse lands 3 clk after the pin edge.
    if (hs_rise_q)               pcnt_d = 12'd0;
    else if (pcnt_q == TMO_CNT)  pcnt_d = pcnt_q;
    else                         pcnt_d = pcnt_q + 12'd1;

    timeout = (pcnt_d == TMO_CNT);
    in_win  = (pcnt_q >= WIN_LO) && (pcnt_q <= WIN_HI);

    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (hs_rise_q) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (hs_rise_q) begin
          if (in_win) begin
            good_d = good_q + GW'(1);
            if (good_d == LOCK_CNT) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (hs_rise_q && !in_win) begin
          state_d = MEASURE;
          good_d  = '0;
        end else if (timeout) begin
          state_d = SEARCH;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase

    if (!bus.enable) begin
      state_d = SEARCH;
      good_d  = '0;
    end

    // Output-side activity only happens while locked on both sides of the edge;
    // the edge that leaves LOCKED freezes dbl_line and clears dbl_vsync.
    stay_locked  = (state_q == LOCKED) && (state_d == LOCKED);
    line_reset_d = hs_rise_q && stay_locked;
    tick         = line_reset_d || (stay_locked && (pcnt_q == MID_CNT));
    locked_d     = (state_d == LOCKED);

    dbl_line_d = dbl_line_q;
    if (stay_locked) begin
      if (vs_rise_q)                            dbl_line_d = 10'd0;
      else if (tick && (dbl_line_q != 10'h3FF)) dbl_line_d = dbl_line_q + 10'd1;
    end

    dbl_vsync_d = dbl_vsync_q;
    vs_cnt_d    = vs_cnt_q;
    if (!stay_locked) begin
      dbl_vsync_d = 1'b0;
      vs_cnt_d    = '0;
    end else if (vs_rise_q) begin
      dbl_vsync_d = 1'b1;
      vs_cnt_d    = VS_CNT;
    end else if (tick && dbl_vsync_q) begin
      vs_cnt_d = vs_cnt_q - VS_ONE;
      if (vs_cnt_q == VS_ONE) dbl_vsync_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= SEARCH;
      hs_s1_q      <= 1'b0;
      hs_s2_q      <= 1'b0;
      hs_rise_q    <= 1'b0;
      vs_s1_q      <= 1'b0;
      vs_s2_q      <= 1'b0;
      vs_rise_q    <= 1'b0;
      pcnt_q       <= 12'd0;
      good_q       <= '0;
      vs_cnt_q     <= '0;
      dbl_line_q   <= 10'd0;
      line_reset_q <= 1'b0;
      dbl_vsync_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_s1_q      <= hs_s1_d;
      hs_s2_q      <= hs_s2_d;
      hs_rise_q    <= hs_rise_d;
      vs_s1_q      <= vs_s1_d;
      vs_s2_q      <= vs_s2_d;
      vs_rise_q    <= vs_rise_d;
      pcnt_q       <= pcnt_d;
      good_q       <= good_d;
      vs_cnt_q     <= vs_cnt_d;
      dbl_line_q   <= dbl_line_d;
      line_reset_q <= line_reset_d;
      dbl_vsync_q  <= dbl_vsync_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.line_reset = line_reset_q;
  assign bus.dbl_vsync  = dbl_vsync_q;
  assign bus.locked     = locked_q;
  assign bus.dbl_line   = dbl_line_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_cga_scandbl_ctrl.sv
// Bench for cga_scandbl_ctrl: directed hsync/vsync sequences, expected output
// events queued ahead of time and matched by an independent monitor.
module tb_cga_scandbl_ctrl;

  localparam int EW   = 44;
  localparam int HS_W = 64;

  localparam logic [1:0] EV_LR   = 2'd0;
  localparam logic [1:0] EV_LOCK = 2'd1;
  localparam logic [1:0] EV_DVR  = 2'd2;
  localparam logic [1:0] EV_DVF  = 2'd3;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   p;

  logic [EW-1:0] exp_q[$];

  cga_scandbl_ctrl_if bus_if ();

  cga_scandbl_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] mk(input logic [1:0] k, input int c, input int d);
    logic [31:0] cv;
    logic [9:0]  dv;
    cv = c;
    dv = d[9:0];
    return {k, cv, dv};
  endfunction

  task automatic push_ev(input logic [1:0] k, input int c, input int d);
    exp_q.push_back(mk(k, c, d));
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic rise_hs(input bit with_vs);
    bus_if.hsync = 1'b1;
    if (with_vs) bus_if.vsync = 1'b1;
    wait_clk(HS_W);
    bus_if.hsync = 1'b0;
    bus_if.vsync = 1'b0;
  endtask

  task automatic line(input int period, input bit with_vs);
    rise_hs(with_vs);
    wait_clk(period - HS_W);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_locked = 1'b0;
  logic prev_dv     = 1'b0;

  task automatic ev_check(input logic [EW-1:0] got);
    logic [EW-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got unexpected kind=%0d cyc=%0d data=%0d, expected none",
               got[43:42], got[41:10], got[9:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL event: got kind=%0d cyc=%0d data=%0d, expected kind=%0d cyc=%0d data=%0d",
                 got[43:42], got[41:10], got[9:0], exp[43:42], exp[41:10], exp[9:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus_if.locked !== prev_locked)
        ev_check(mk(EV_LOCK, cyc, {9'd0, bus_if.locked}));
      if (bus_if.dbl_vsync !== prev_dv)
        ev_check(mk(bus_if.dbl_vsync ? EV_DVR : EV_DVF, cyc, bus_if.dbl_line));
      if (bus_if.line_reset === 1'b1)
        ev_check(mk(EV_LR, cyc, bus_if.dbl_line));
      prev_locked = bus_if.locked;
      prev_dv     = bus_if.dbl_vsync;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n       = 1'b0;
    bus_if.enable = 1'b1;
    bus_if.hsync  = 1'b0;
    bus_if.vsync  = 1'b0;

    // Reset held 5 clk, then idle with no sync
    wait_clk(5);
    chk("rst_locked",     int'(bus_if.locked),     0);
    chk("rst_line_reset", int'(bus_if.line_reset), 0);
    chk("rst_dbl_vsync",  int'(bus_if.dbl_vsync),  0);
    chk("rst_dbl_line",   int'(bus_if.dbl_line),   0);
    chk("rst_state",      int'(bus_if.state_dbg),  0);
    reset_n = 1'b1;
    wait_clk(5000);
    chk("idle_locked",    int'(bus_if.locked),     0);
    chk("idle_dbl_vsync", int'(bus_if.dbl_vsync),  0);
    chk("idle_dbl_line",  int'(bus_if.dbl_line),   0);

    // Nominal lines: lock on the 5th rise, swap pulses from the 6th on
    for (int k = 1; k <= 8; k++) begin
      p = cyc;
      if (k == 5) push_ev(EV_LOCK, p + 3, 1);
      if (k >= 6) push_ev(EV_LR, p + 3, 2 * (k - 5));
      line(1824, 1'b0);
    end

    // Long line drops lock; relock through both window edges
    p = cyc; push_ev(EV_LR, p + 3, 8);   line(1900, 1'b0);
    p = cyc; push_ev(EV_LOCK, p + 3, 0); line(1824, 1'b0);
    line(1793, 1'b0);
    line(1857, 1'b0);
    line(1824, 1'b0);
    p = cyc; push_ev(EV_LOCK, p + 3, 1); line(1824, 1'b0);
    p = cyc; push_ev(EV_LR, p + 3, 11);  line(1824, 1'b0);

    // Vsync with last hsync, then hsync stops: timeout clears lock and dbl_vsync
    p = cyc;
    push_ev(EV_DVR, p + 3, 0);
    push_ev(EV_LR,  p + 3, 0);
    push_ev(EV_LOCK, p + 3 + 4095, 0);
    push_ev(EV_DVF,  p + 3 + 4095, 1);
    line(1824, 1'b1);
    wait_clk(2400);

    // Relock, then vsync coincident with hsync rise
    for (int k = 17; k <= 21; k++) begin
      p = cyc;
      if (k == 21) push_ev(EV_LOCK, p + 3, 1);
      line(1824, 1'b0);
    end
    p = cyc;
    push_ev(EV_DVR, p + 3, 0);
    push_ev(EV_LR,  p + 3, 0);
    rise_hs(1'b1);
    wait_clk(914 - HS_W);
    chk("mid_before", int'(bus_if.dbl_line), 0);
    wait_clk(1);
    chk("mid_tick", int'(bus_if.dbl_line), 1);
    chk("mid_dbl_vsync", int'(bus_if.dbl_vsync), 1);
    wait_clk(1824 - 915);
    p = cyc;
    push_ev(EV_DVF, p + 3, 2);
    push_ev(EV_LR,  p + 3, 2);
    line(1824, 1'b0);

    // Enable dropped mid-line while dbl_vsync is active, then relock
    p = cyc;
    push_ev(EV_DVR, p + 3, 0);
    push_ev(EV_LR,  p + 3, 0);
    rise_hs(1'b1);
    wait_clk(1200 - HS_W);
    push_ev(EV_LOCK, p + 1201, 0);
    push_ev(EV_DVF,  p + 1201, 1);
    bus_if.enable = 1'b0;
    wait_clk(300);
    chk("dis_dbl_line", int'(bus_if.dbl_line), 1);
    bus_if.enable = 1'b1;
    wait_clk(324);
    for (int k = 25; k <= 29; k++) begin
      p = cyc;
      if (k == 29) push_ev(EV_LOCK, p + 3, 1);
      line(1824, 1'b0);
    end
    p = cyc;
    push_ev(EV_LR, p + 3, 3);
    rise_hs(1'b0);
    wait_clk(100);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending events expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
